// File: rtl/sram_turn_scheduler_if.sv
// rtl/sram_turn_scheduler_if.sv - CPU/video request inputs and SRAM turn/status outputs of the scheduler
interface sram_turn_scheduler_if #(
    parameter int WINDOW = 8
);
    localparam int PW = $clog2(WINDOW);

    logic          vid_active;
    logic          mreq_n;
    logic          rfsh_n;
    logic          stat_clr;
    logic          whichturn;
    logic          cpu_wait_n;
    logic [15:0]   wait_cnt;
    logic          overrun;
    logic [PW-1:0] phase;

    modport master (
        output vid_active, mreq_n, rfsh_n, stat_clr,
        input  whichturn, cpu_wait_n, wait_cnt, overrun, phase
    );

    modport slave (
        input  vid_active, mreq_n, rfsh_n, stat_clr,
        output whichturn, cpu_wait_n, wait_cnt, overrun, phase
    );
endinterface

// File: rtl/sram_turn_scheduler.sv
// rtl/sram_turn_scheduler.sv - Time-slices one SRAM between video fetch and CPU accesses, video first
module sram_turn_scheduler #(
    parameter int WINDOW      = 8,
    parameter int ASIC_PHASES = 4,
    parameter int ACC_LEN     = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_turn_scheduler_if.slave  bus
);
    localparam int             PW         = $clog2(WINDOW);
    localparam logic [PW-1:0]  LAST_PHASE = PW'(WINDOW - 1);
    localparam logic [PW-1:0]  ASIC_END   = PW'(ASIC_PHASES);
    localparam logic [PW:0]    WIN_W      = (PW+1)'(WINDOW);
    localparam logic [PW:0]    ACC_W      = (PW+1)'(ACC_LEN);

    typedef enum logic [1:0] {IDLE, WAITING, GRANTED} state_t;

    state_t        state, state_next;
    logic [PW-1:0] phase, phase_next;
    logic          vid_active_l, vid_active_l_next;
    logic          whichturn, whichturn_next;
    logic          cpu_wait_n;
    logic          overrun;
    logic [15:0]   wait_cnt;
    logic          cpu_req;
    logic          can_start;
    logic [PW:0]   remain;

    // whichturn is registered from next-cycle phase so it changes together with phase.
    always_comb begin
        phase_next        = phase + PW'(1);
        vid_active_l_next = (phase == LAST_PHASE) ? bus.vid_active : vid_active_l;
        whichturn_next    = vid_active_l_next && (phase_next < ASIC_END);
        cpu_req           = !bus.mreq_n && bus.rfsh_n;
        remain            = WIN_W - {1'b0, phase};
        can_start         = (!vid_active_l || (phase >= ASIC_END)) && (remain >= ACC_W);
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (cpu_req) state_next = can_start ? GRANTED : WAITING;
            end
            WAITING: begin
                if (!cpu_req)      state_next = IDLE;
                else if (can_start) state_next = GRANTED;
            end
            GRANTED: begin
                if (!cpu_req) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            phase        <= '0;
            vid_active_l <= 1'b0;
            whichturn    <= 1'b0;
            cpu_wait_n   <= 1'b1;
        end else begin
            state        <= state_next;
            phase        <= phase_next;
            vid_active_l <= vid_active_l_next;
            whichturn    <= whichturn_next;
            cpu_wait_n   <= (state_next != WAITING);
        end
    end

    // Overrun marks video reclaiming the SRAM while a CPU access still holds its grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            overrun  <= 1'b0;
        end else if (bus.stat_clr) begin
            wait_cnt <= '0;
            overrun  <= 1'b0;
        end else begin
            if ((state == WAITING) && (wait_cnt != 16'hFFFF)) wait_cnt <= wait_cnt + 16'd1;
            if ((state == GRANTED) && whichturn_next && !whichturn) overrun <= 1'b1;
        end
    end

    assign bus.whichturn  = whichturn;
    assign bus.cpu_wait_n = cpu_wait_n;
    assign bus.wait_cnt   = wait_cnt;
    assign bus.overrun    = overrun;
    assign bus.phase      = phase;
endmodule
